// File: rtl/mau_pkg.sv
// Shared encodings for the MEM-stage memory access unit: access sizes and FSM states.
package mau_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } mau_state_t;

endpackage

// File: rtl/mau_lane_unit.sv
// Combinational lane logic: load extract/extend and sub-word store merge, little-endian lanes.
module mau_lane_unit
  import mau_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        isUnsigned,
  input  logic [31:0] rdWord,
  input  logic [31:0] wrData,
  output logic [31:0] loadData,
  output logic [31:0] mergedWord
);

  logic [4:0]  byteOfs;
  logic [4:0]  halfOfs;
  logic [7:0]  byteVal;
  logic [15:0] halfVal;

  assign byteOfs = {lane, 3'b000};
  assign halfOfs = {lane[1], 4'b0000};
  assign byteVal = rdWord[byteOfs +: 8];
  assign halfVal = rdWord[halfOfs +: 16];

  // NOTE: every output of an always_comb gets a default before the case, so no path can infer a latch.
  always_comb begin
    loadData   = rdWord;
    mergedWord = wrData;
    case (size)
      SZ_BYTE: begin
        loadData                  = {{24{~isUnsigned & byteVal[7]}}, byteVal};
        mergedWord                = rdWord;
        mergedWord[byteOfs +: 8]  = wrData[7:0];
      end
      SZ_HALF: begin
        loadData                  = {{16{~isUnsigned & halfVal[15]}}, halfVal};
        mergedWord                = rdWord;
        mergedWord[halfOfs +: 16] = wrData[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for the word-organised data memory; sub-word stores use a two-cycle RMW.
// Build option: define MAU_ALIGN_TRAP_EN to error misaligned accesses instead of force-aligning them.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_load,
  input  logic              req_is_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_error,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [31:0]       mem_wr_data,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [31:0]       mem_rd_data
);

  mau_state_t        state;
  logic [31:0]       bufWord;
  logic [ADDR_W-1:0] bufAddr;

  logic [ADDR_W-1:0] wordAddr;
  logic              isIllegal;
  logic              isMisaligned;
  logic              reqError;
  logic [1:0]        lane;
  logic              isSubStore;
  logic              accept;
  logic [31:0]       loadData;
  logic [31:0]       mergedWord;
  logic              unusedAddrBits;

  // Upper byte-address bits are dropped so addresses wrap within the memory.
  assign wordAddr       = req_addr[ADDR_W+1:2];
  assign unusedAddrBits = ^req_addr[31:ADDR_W+2];

  assign isIllegal    = (req_size == SZ_ILL) || (req_is_load && req_is_store);
  assign isMisaligned = ((req_size == SZ_HALF) && req_addr[0]) ||
                        ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

`ifdef MAU_ALIGN_TRAP_EN
  assign reqError = isIllegal || isMisaligned;
  assign lane     = req_addr[1:0];
`else
  assign reqError = isIllegal;
  assign lane     = (req_size == SZ_WORD) ? 2'b00 :
                    (req_size == SZ_HALF) ? {req_addr[1], 1'b0} : req_addr[1:0];
`endif

  assign accept     = req_valid && (state == IDLE) && !reqError;
  assign isSubStore = req_is_store && !req_is_load && (req_size != SZ_WORD);

  mau_lane_unit u_lane (
    .lane       (lane),
    .size       (req_size),
    .isUnsigned (req_unsigned),
    .rdWord     (mem_rd_data),
    .wrData     (req_wdata),
    .loadData   (loadData),
    .mergedWord (mergedWord)
  );

  assign req_ready = (state == IDLE);

  // Enables are gated by rst_n so a reset in RMW_WR aborts the pending write immediately.
  assign mem_rd_en   = rst_n && accept && (req_is_load || isSubStore);
  assign mem_wr_en   = rst_n && ((state == RMW_WR) ||
                                 (accept && req_is_store && !isSubStore));
  assign mem_rd_addr = wordAddr;
  assign mem_wr_addr = (state == RMW_WR) ? bufAddr : wordAddr;
  assign mem_wr_data = (state == RMW_WR) ? bufWord : req_wdata;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= '0;
      bufWord    <= '0;
      bufAddr    <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= '0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (reqError) begin
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
            end else if (isSubStore) begin
              state   <= RMW_WR;
              bufWord <= mergedWord;
              bufAddr <= wordAddr;
            end else begin
              resp_valid <= 1'b1;
              if (req_is_load) resp_rdata <= loadData;
            end
          end
        end
        RMW_WR: begin
          state      <= IDLE;
          resp_valid <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a word memory model (comb read, sync write).
module tb_mem_access_unit;
  import mau_pkg::*;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready, req_is_load, req_is_store, req_unsigned;
  logic [1:0]        req_size;
  logic [31:0]       req_addr, req_wdata;
  logic              resp_valid, resp_error;
  logic [31:0]       resp_rdata;
  logic              mem_wr_en, mem_rd_en;
  logic [ADDR_W-1:0] mem_wr_addr, mem_rd_addr;
  logic [31:0]       mem_wr_data, mem_rd_data;

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  int nVec = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
  assign mem_rd_data = mem[mem_rd_addr];

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_load(req_is_load), .req_is_store(req_is_store),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setReq(input logic v, input logic ld, input logic st, input logic [1:0] sz,
                        input logic un, input logic [31:0] a, input logic [31:0] wd);
    req_valid    = v;
    req_is_load  = ld;
    req_is_store = st;
    req_size     = sz;
    req_unsigned = un;
    req_addr     = a;
    req_wdata    = wd;
  endtask

  // Applies a load at the current negedge and checks its response one cycle later.
  task automatic loadCheck(input string tag, input logic [1:0] sz, input logic un,
                           input logic [31:0] a, input logic [31:0] exp);
    setReq(1, 1, 0, sz, un, a, 32'h0);
    #1 check({tag, " rd_en"}, mem_rd_en, 1);
    @(negedge clk);
    check({tag, " valid"}, resp_valid, 1);
    check({tag, " error"}, resp_error, 0);
    check({tag, " rdata"}, resp_rdata, exp);
  endtask

  // Applies a request expected to error and checks that no memory port is enabled.
  task automatic errorCheck(input string tag, input logic ld, input logic st,
                            input logic [1:0] sz, input logic [31:0] a);
    setReq(1, ld, st, sz, 0, a, 32'hDEAD_BEEF);
    #1 check({tag, " no enables"}, {mem_rd_en, mem_wr_en}, 0);
    @(negedge clk);
    check({tag, " valid"}, resp_valid, 1);
    check({tag, " error"}, resp_error, 1);
    check({tag, " rdata"}, resp_rdata, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    setReq(1, 1, 0, SZ_WORD, 0, 32'h14, 32'h0);
    #1;
    check("reset rd_en gated", mem_rd_en, 0);
    check("reset wr_en", mem_wr_en, 0);
    check("reset resp_valid", resp_valid, 0);
    check("reset resp_error", resp_error, 0);
    check("reset resp_rdata", resp_rdata, 0);
    check("reset req_ready", req_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Preload words 5 and 6 with word stores through the unit.
    setReq(1, 0, 1, SZ_WORD, 0, 32'h14, 32'h1122_3344);
    #1;
    check("sw5 wr_en", mem_wr_en, 1);
    check("sw5 wr_addr", mem_wr_addr, 5);
    check("sw5 wr_data", mem_wr_data, 32'h1122_3344);
    check("sw5 rd_en", mem_rd_en, 0);
    @(negedge clk);
    check("sw5 valid", resp_valid, 1);
    check("sw5 rdata", resp_rdata, 0);
    setReq(1, 0, 1, SZ_WORD, 0, 32'h18, 32'h8001_7F80);
    @(negedge clk);
    check("sw6 valid", resp_valid, 1);
    check("mem5 preload", mem[5], 32'h1122_3344);
    check("mem6 preload", mem[6], 32'h8001_7F80);

    loadCheck("lb 0x15", SZ_BYTE, 0, 32'h15, 32'h0000_0033);
    loadCheck("lb 0x17", SZ_BYTE, 0, 32'h17, 32'h0000_0011);
    loadCheck("lw 0x14", SZ_WORD, 0, 32'h14, 32'h1122_3344);
    loadCheck("lh 0x1A", SZ_HALF, 0, 32'h1A, 32'hFFFF_8001);
    loadCheck("lhu 0x1A", SZ_HALF, 1, 32'h1A, 32'h0000_8001);
    loadCheck("lb 0x18", SZ_BYTE, 0, 32'h18, 32'hFFFF_FF80);
    loadCheck("lbu 0x18", SZ_BYTE, 1, 32'h18, 32'h0000_0080);

    // Sub-word store RMW, with a load held on the inputs while the unit is busy.
    setReq(1, 0, 1, SZ_BYTE, 0, 32'h16, 32'h0000_00AB);
    #1;
    check("sb c0 ready", req_ready, 1);
    check("sb c0 rd_en", mem_rd_en, 1);
    check("sb c0 wr_en", mem_wr_en, 0);
    @(negedge clk);
    setReq(1, 1, 0, SZ_WORD, 0, 32'h14, 32'h0);
    #1;
    check("sb c1 ready", req_ready, 0);
    check("sb c1 wr_en", mem_wr_en, 1);
    check("sb c1 rd_en", mem_rd_en, 0);
    check("sb c1 wr_addr", mem_wr_addr, 5);
    check("sb c1 wr_data", mem_wr_data, 32'h11AB_3344);
    check("sb c1 valid", resp_valid, 0);
    @(negedge clk);
    check("sb c2 valid", resp_valid, 1);
    check("sb c2 error", resp_error, 0);
    check("sb c2 rdata", resp_rdata, 0);
    check("sb mem5", mem[5], 32'h11AB_3344);
    check("sb c2 ready", req_ready, 1);
    loadCheck("lw after sb", SZ_WORD, 0, 32'h14, 32'h11AB_3344);

    errorCheck("size 11", 1, 0, SZ_ILL, 32'h14);
    errorCheck("load+store", 1, 1, SZ_WORD, 32'h14);
`ifdef MAU_ALIGN_TRAP_EN
    errorCheck("lw 0x15", 1, 0, SZ_WORD, 32'h15);
    errorCheck("lh 0x13", 1, 0, SZ_HALF, 32'h13);
    errorCheck("sh 0x17", 0, 1, SZ_HALF, 32'h17);
`else
    loadCheck("lw 0x15 aligned", SZ_WORD, 0, 32'h15, 32'h11AB_3344);
    loadCheck("lh 0x1B aligned", SZ_HALF, 0, 32'h1B, 32'hFFFF_8001);
`endif

    // NOP: accepted, no memory traffic, empty response.
    setReq(1, 0, 0, SZ_WORD, 0, 32'h14, 32'h1234_5678);
    #1 check("nop enables", {mem_rd_en, mem_wr_en}, 0);
    @(negedge clk);
    check("nop valid", resp_valid, 1);
    check("nop error", resp_error, 0);
    check("nop rdata", resp_rdata, 0);

    loadCheck("lw wrap 0x1014", SZ_WORD, 0, 32'h1014, 32'h11AB_3344);

    // Reset while the RMW write is pending aborts it.
    setReq(1, 0, 1, SZ_HALF, 0, 32'h16, 32'h0000_BEEF);
    @(negedge clk);
    setReq(0, 0, 0, SZ_WORD, 0, 32'h14, 32'h0);
    #1 check("rmw pre-reset wr_en", mem_wr_en, 1);
    rst_n = 1'b0;
    #1 check("rmw reset wr_en", mem_wr_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rmw reset mem5", mem[5], 32'h11AB_3344);
    check("rmw reset valid", resp_valid, 0);
    check("rmw reset ready", req_ready, 1);
    @(negedge clk);
    check("rmw reset no late valid", resp_valid, 0);

    // Same half store without reset completes.
    setReq(1, 0, 1, SZ_HALF, 0, 32'h16, 32'h0000_BEEF);
    @(negedge clk);
    setReq(0, 0, 0, SZ_WORD, 0, 32'h14, 32'h0);
    @(negedge clk);
    check("sh valid", resp_valid, 1);
    check("sh mem5", mem[5], 32'hBEEF_3344);
    loadCheck("lhu 0x16", SZ_HALF, 1, 32'h16, 32'h0000_BEEF);
    setReq(0, 0, 0, SZ_WORD, 0, 32'h0, 32'h0);
    @(negedge clk);
    check("idle valid", resp_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
